// File: rtl/sr_bank_arbiter.sv
// rtl/sr_bank_arbiter.sv - round-robin arbiter sharing one SR flip-flop bank; optional SR_ARB_READBACK_CHECK_EN
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int IDXW  = 3,
    parameter int PULSE = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic [W-1:0]         S,
    output logic [W-1:0]         R,
    output logic                 busy,
    output logic                 done,
    output logic                 bad_idx,
    input  logic [W-1:0]         q_in,
    output logic                 chk_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     last_q;
    logic              op_q;
    logic [IDXW-1:0]   idx_q;
    logic [CW-1:0]     cnt_q;
    logic [NREQ-1:0]   gnt_q;
    logic [W-1:0]      s_q;
    logic [W-1:0]      r_q;
    logic              busy_q;
    logic              done_q;
    logic              bad_q;
    logic              chk_q;

    logic              win_found_d;
    logic [PW-1:0]     win_ptr_d;
    logic [NREQ-1:0]   win_gnt_d;
    logic              win_op_d;
    logic [IDXW-1:0]   win_idx_d;
    logic [W-1:0]      win_bit_d;
    logic              idx_ok;

    // Round-robin pick: first requester after the last winner, wrapping modulo NREQ
    always_comb begin
        win_found_d = 1'b0;
        win_ptr_d   = '0;
        win_gnt_d   = '0;
        win_op_d    = 1'b0;
        win_idx_d   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found_d && req[i] && (i == ((int'(last_q) + k) % NREQ))) begin
                    win_found_d = 1'b1;
                    win_ptr_d   = PW'(i);
                    win_gnt_d   = NREQ'(1) << i;
                    win_op_d    = op[i];
                    win_idx_d   = idx[i*IDXW +: IDXW];
                end
            end
        end
    end

    // An out-of-range index shifts the single set bit off the top, so S/R stay all-zero
    assign win_bit_d = W'(1) << win_idx_d;
    assign idx_ok    = ({{(32-IDXW){1'b0}}, idx_q} < 32'(W));

`ifdef SR_ARB_READBACK_CHECK_EN
    logic [W-1:0] cap_bit;
    logic         rb_bit;
    assign cap_bit = W'(1) << idx_q;
    assign rb_bit  = |(q_in & cap_bit);
`else
    logic unused_q_in;
    assign unused_q_in = ^q_in;
`endif

    // Arbitration FSM with all outputs registered; S and R are never loaded from the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= PW'(NREQ-1);
            op_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
            chk_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    bad_q  <= 1'b0;
                    if (win_found_d) begin
                        state_q <= ST_DRIVE;
                        last_q  <= win_ptr_d;
                        op_q    <= win_op_d;
                        idx_q   <= win_idx_d;
                        cnt_q   <= CW'(PULSE-1);
                        gnt_q   <= win_gnt_d;
                        s_q     <= win_op_d ? win_bit_d : '0;
                        r_q     <= win_op_d ? '0 : win_bit_d;
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q  <= '0;
                        s_q    <= '0;
                        r_q    <= '0;
                        busy_q <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    gnt_q <= '0;
                    if (cnt_q == '0) begin
                        state_q <= ST_SETTLE;
                        s_q     <= '0;
                        r_q     <= '0;
                        done_q  <= 1'b1;
                        bad_q   <= !idx_ok;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_SETTLE: begin
`ifdef SR_ARB_READBACK_CHECK_EN
                    if (idx_ok && (rb_bit != op_q)) begin
                        chk_q <= 1'b1;
                    end
`endif
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    bad_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    s_q     <= '0;
                    r_q     <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    bad_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign S       = s_q;
    assign R       = r_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bad_idx = bad_q;
    assign chk_err = chk_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb/tb_sr_bank_arbiter.sv - self-checking bench for sr_bank_arbiter (NREQ=4, W=6, PULSE=2)
module tb_sr_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 6;
    localparam int IDXW  = 3;
    localparam int PULSE = 2;

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  op;
        logic [11:0] idx;
        logic [3:0]  gnt;
        logic [5:0]  s;
        logic [5:0]  r;
        logic        bad;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  op = '0;
    logic [11:0] idx = '0;
    logic [3:0]  gnt;
    logic [5:0]  S;
    logic [5:0]  R;
    logic        busy;
    logic        done;
    logic        bad_idx;
    logic [5:0]  q_in;
    logic        chk_err;

    logic [5:0]  bank = '0;
    logic        force_q3 = 1'b0;
    logic        mon_en = 1'b0;
    logic        exp_chk;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[8];
    vec_t exp_q[$];

    sr_bank_arbiter #(.NREQ(NREQ), .W(W), .IDXW(IDXW), .PULSE(PULSE)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op(op), .idx(idx),
        .gnt(gnt), .S(S), .R(R), .busy(busy), .done(done), .bad_idx(bad_idx),
        .q_in(q_in), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bank <= (bank & ~R) | S;
    assign q_in = bank | (force_q3 ? 6'b001000 : 6'b000000);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariant monitor: never S=R=1 on a bit, never more than one bit driven
    always @(negedge clk) begin
        if (mon_en) begin
            chk("s_and_r", 32'(S & R), 32'd0);
            chk("one_bit", 32'($countones(S | R) <= 1), 32'd1);
        end
    end

    task automatic run_op(input vec_t v);
        int   cnt;
        vec_t e;
        @(negedge clk);
        req = v.req; op = v.op; idx = v.idx;
        exp_q.push_back(v);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (gnt == '0 && cnt < 20);
        req = '0;
        if (gnt == '0) begin
            chk("gnt_timeout", 32'd1, 32'd0);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("gnt_latency", 32'(cnt), 32'd1);
            chk("s_pulse1", 32'(S), 32'(e.s));
            chk("r_pulse1", 32'(R), 32'(e.r));
            chk("busy_drive", 32'(busy), 32'd1);
            chk("done_drive", 32'(done), 32'd0);
            @(negedge clk);
            chk("gnt_once", 32'(gnt), 32'd0);
            chk("s_pulse2", 32'(S), 32'(e.s));
            chk("r_pulse2", 32'(R), 32'(e.r));
            @(negedge clk);
            chk("s_settle", 32'(S), 32'd0);
            chk("r_settle", 32'(R), 32'd0);
            chk("done_settle", 32'(done), 32'd1);
            chk("bad_settle", 32'(bad_idx), 32'(e.bad));
            @(negedge clk);
            chk("done_idle", 32'(done), 32'd0);
            chk("bad_idle", 32'(bad_idx), 32'd0);
            chk("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   prev;
        int   ngr;
        int   cnt;
        logic [1:0] elast;
        logic [3:0] egnt;

`ifdef SR_ARB_READBACK_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif

        vecs[0] = '{req:4'b0110, op:4'b0100, idx:{3'd0,3'd4,3'd2,3'd0}, gnt:4'b0010, s:6'b000000, r:6'b000100, bad:1'b0};
        vecs[1] = '{req:4'b0110, op:4'b0100, idx:{3'd0,3'd4,3'd2,3'd0}, gnt:4'b0100, s:6'b010000, r:6'b000000, bad:1'b0};
        vecs[2] = '{req:4'b1001, op:4'b1000, idx:{3'd0,3'd0,3'd0,3'd1}, gnt:4'b1000, s:6'b000001, r:6'b000000, bad:1'b0};
        vecs[3] = '{req:4'b1001, op:4'b1000, idx:{3'd0,3'd0,3'd0,3'd1}, gnt:4'b0001, s:6'b000000, r:6'b000010, bad:1'b0};
        vecs[4] = '{req:4'b0100, op:4'b0000, idx:{3'd0,3'd7,3'd0,3'd0}, gnt:4'b0100, s:6'b000000, r:6'b000000, bad:1'b1};
        vecs[5] = '{req:4'b0001, op:4'b0001, idx:{3'd0,3'd0,3'd0,3'd6}, gnt:4'b0001, s:6'b000000, r:6'b000000, bad:1'b1};
        vecs[6] = '{req:4'b1000, op:4'b0000, idx:{3'd5,3'd0,3'd0,3'd0}, gnt:4'b1000, s:6'b000000, r:6'b100000, bad:1'b0};
        vecs[7] = '{req:4'b1111, op:4'b1111, idx:{3'd2,3'd0,3'd1,3'd3}, gnt:4'b0001, s:6'b001000, r:6'b000000, bad:1'b0};

        // Reset held with random inputs
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = 4'($urandom); op = 4'($urandom); idx = 12'($urandom);
        end
        @(negedge clk);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_chk", 32'(chk_err), 32'd0);
        reset_n = 1'b1;
        req = '0; op = '0; idx = '0;

        // First operation after reset: requester 0 sets bit 5
        v = '{req:4'b0001, op:4'b0001, idx:{3'd0,3'd0,3'd0,3'd5}, gnt:4'b0001, s:6'b100000, r:6'b000000, bad:1'b0};
        run_op(v);

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Contention: all four request continuously
        @(negedge clk);
        req = 4'b1111; op = 4'b1010; idx = {3'd0,3'd1,3'd2,3'd3};
        elast = 2'd0;
        prev = 0;
        ngr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                elast = elast + 2'd1;
                egnt = 4'b0001 << elast;
                chk("rr_gnt", 32'(gnt), 32'(egnt));
                if (ngr > 0) chk("rr_spacing", 32'(c - prev), 32'(PULSE + 2));
                prev = c;
                ngr++;
            end
        end
        req = '0;
        chk("rr_count", 32'(ngr), 32'd10);
        repeat (4) @(negedge clk);

        // Mid-operation reset: requester 2 in flight (pointer now 2)
        req = 4'b0100; op = 4'b0100; idx = {3'd0,3'd1,3'd0,3'd0};
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (gnt == '0 && cnt < 20);
        req = '0;
        chk("mid_gnt", 32'(gnt), 32'b0100);
        chk("mid_S", 32'(S), 32'b000010);
        reset_n = 1'b0;
        #1;
        chk("mid_S_async", 32'(S), 32'd0);
        chk("mid_R_async", 32'(R), 32'd0);
        chk("mid_busy_async", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        v = '{req:4'b1100, op:4'b1100, idx:{3'd4,3'd3,3'd0,3'd0}, gnt:4'b0100, s:6'b001000, r:6'b000000, bad:1'b0};
        run_op(v);

        // Readback: clear bit 3 while q_in[3] is forced high, then a correct op
        force_q3 = 1'b1;
        v = '{req:4'b0001, op:4'b0000, idx:{3'd0,3'd0,3'd0,3'd3}, gnt:4'b0001, s:6'b000000, r:6'b001000, bad:1'b0};
        run_op(v);
        chk("rb_err_set", 32'(chk_err), 32'(exp_chk));
        force_q3 = 1'b0;
        v = '{req:4'b0010, op:4'b0010, idx:{3'd0,3'd0,3'd2,3'd0}, gnt:4'b0010, s:6'b000000, r:6'b000000, bad:1'b0};
        v.s = 6'b000100;
        run_op(v);
        chk("rb_err_sticky", 32'(chk_err), 32'(exp_chk));
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rb_err_cleared", 32'(chk_err), 32'd0);
        reset_n = 1'b1;

        // Random stress for the invariant
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            req = 4'($urandom); op = 4'($urandom); idx = 12'($urandom);
        end
        req = '0;
        repeat (6) @(negedge clk);
        chk("stress_idle", 32'(busy), 32'd0);
        chk("stress_chk", 32'(chk_err), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
- Round-robin controller that shares one bank of W positive-edge SR flip-flops between NREQ requesters.
- Each requester asks for one operation: set or clear a single bit of the bank.
- The block grants one request at a time and drives registered S/R pulse buses into the bank.
- It guarantees that S=R=1 (the invalid combination) is never presented on any bit. It sits between software-visible command sources and the SR flop bank.

Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 8: number of SR flip-flops in the bank.
- IDXW, 3: width of the bit index; must satisfy 2^IDXW >= W.
- PULSE, 2: number of cycles S or R is held high per operation (>=1).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request, level.
- op  input  NREQ  per-requester operation: 1 = set, 0 = clear.
- idx  input  NREQ*IDXW  per-requester target bit; requester i uses bits [i*IDXW +: IDXW].
- gnt  output  NREQ  one-hot grant, 1-cycle pulse.
- S  output  W  set bus to the bank.
- R  output  W  reset bus to the bank.
- busy  output  1  high whenever state != IDLE.
- done  output  1  1-cycle pulse when an operation completes.
- bad_idx  output  1  1-cycle pulse, coincident with done, when the granted idx >= W.
- q_in  input  W  Q feedback from the bank; used only with the optional feature.
- chk_err  output  1  sticky readback error; used only with the optional feature.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, gnt=0, S=0, R=0, busy=0, done=0, bad_idx=0, chk_err=0, last-grant pointer=NREQ-1. Requester 0 therefore wins first after reset.
- All outputs are registered.
- FSM states: IDLE, DRIVE, SETTLE.
- IDLE:
  - On an edge where any req is high, pick the winner by round-robin: first requester with req=1 searching last+1, last+2, ... modulo NREQ.
  - Capture the winner's op and idx, update last to the winner, and assert gnt[winner] for exactly the following cycle.
  - Go to DRIVE with a pulse counter loaded to PULSE-1.
  - With no req, stay in IDLE.
- DRIVE:
  - If the captured idx < W: S[idx]=op and R[idx]=~op. All other S/R bits are 0.
  - If idx >= W: S=R=0 for all bits.
  - Stays in DRIVE for exactly PULSE cycles, counter decrementing each cycle.
  - At counter=0, go to SETTLE with S=R=0 on that edge.
- SETTLE:
  - Lasts one cycle with done=1; bad_idx=1 if the captured idx >= W.
  - Go to IDLE. SETTLE never grants.
- Latency and throughput: gnt appears in the cycle after the requesting edge, and the S/R pulse starts in the same cycle as gnt. One operation occupies PULSE+2 cycles edge-to-edge, counting the IDLE arbitration cycle.
- Handshake:
  - A requester holds req, op and idx stable until it sees gnt. They are sampled only at the IDLE arbitration edge.
  - Changes after the grant do not affect the operation in flight.
  - Dropping req before grant withdraws the request with no side effect.
  - Holding req high after gnt is a new request, arbitrated fairly against the others.
- Invariant: (S & R) == 0 in every cycle, including reset entry and exit. At most one bit of S|R is high.
- Simultaneous requests are resolved by round-robin only; no requester is granted twice while another continuous requester waits.
- Reset mid-operation: S/R drop to 0 immediately (asynchronously), the operation is abandoned with no done, and the pointer returns to NREQ-1.

Optional Feature:
- Macro: SR_ARB_READBACK_CHECK_EN.
- When defined:
  - In SETTLE with idx < W, compare q_in[idx] against the captured op.
  - On mismatch, chk_err is set and remains 1 until reset.
  - The comparison is skipped for bad_idx operations.
- When undefined: q_in is ignored and chk_err is tied to 0.

Test Plan:
- Reset: hold reset_n=0 with random inputs → S=R=0, gnt=0, busy=0, done=0, chk_err=0. Release, then req=4'b0001, op[0]=1, idx0=5 → gnt=0001 next cycle, S=8'h20 for 2 cycles, then done=1.
- Contention: req=4'b1111 held continuously → grant order 0,1,2,3,0,1…, with consecutive grants exactly PULSE+2=4 cycles apart.
- Out-of-range index: op=0, idx=7 with W=6 → gnt pulses, S=R=0 throughout, done=1 and bad_idx=1 together.
- Mid-operation reset: assert reset_n=0 during DRIVE → S/R go to 0 within the same cycle, no done. After release with req=4'b0100, requester 2 is granted first.
- Readback (macro defined): clear idx=3 while the bank model keeps q_in[3]=1 → chk_err=1 from SETTLE onward and stays 1 through subsequent correct operations until reset.
- Continuous invariant: under a random stress run of 10k cycles, (S&R)==0 and popcount(S|R)<=1 hold in every cycle.
